// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the RV32 pipeline.
// Byte/half/word loads and stores with sign/zero extension, a fixed-latency
// response pipeline and a response FIFO that absorbs consumer back-pressure.
// Optional build macro: DMEM_MISALIGN_ERR_EN -- when defined, misaligned
// half/word accesses return an error instead of being silently aligned.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 2);
  localparam int FD = LATENCY + 1;
  localparam int PW = $clog2(FD);
  localparam logic [CW-1:0] MAX_OUT  = CW'(LATENCY + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FD - 1);

  logic [31:0]   mem [DEPTH_WORDS];

  logic [CW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic          accept;
  logic          pop;
  logic          push;
  logic [31:0]   push_rdata;
  logic          push_err;

  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic          addr_oob;
  logic          size_bad;
  logic          misalign;
  logic          req_err;

  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [31:0]   load_val;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;

  logic          st0_valid;
  logic [31:0]   st0_rdata;
  logic          st0_err;

  // Outstanding includes responses still in the pipeline, so capping it at
  // the FIFO depth guarantees every in-flight response has a FIFO slot.
  assign req_ready = !rst && (outstanding < MAX_OUT);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  assign word_idx  = req_addr[AW+1:2];
  assign rd_word   = mem[word_idx];
  assign addr_oob  = |req_addr[31:AW+2];
  assign size_bad  = (req_size == 2'b11);

`ifdef DMEM_MISALIGN_ERR_EN
  assign misalign  = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign  = 1'b0;
`endif

  assign req_err   = size_bad || addr_oob || misalign;

  // Lane selection for loads and lane enables/replicated data for stores.
  always_comb begin
    lane_byte = rd_word[{req_addr[1:0], 3'b000} +: 8];
    lane_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_val  = '0;
    wr_be     = '0;
    wr_data   = req_wdata;
    case (req_size)
      2'b00: begin
        load_val = {{24{~req_unsigned & lane_byte[7]}}, lane_byte};
        wr_be    = 4'b0001 << req_addr[1:0];
        wr_data  = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        load_val = {{16{~req_unsigned & lane_half[15]}}, lane_half};
        wr_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data  = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        load_val = rd_word;
        wr_be    = 4'b1111;
      end
      default: begin
        load_val = '0;
        wr_be    = '0;
      end
    endcase
  end

  assign st0_valid = accept;
  assign st0_err   = req_err;
  assign st0_rdata = (req_write || req_err) ? '0 : load_val;

  // Store side effect lands on the accept edge; loads above saw the old word.
  always_ff @(posedge clk) begin
    if (accept && req_write && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Outstanding request count: up on accept, down on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // The FIFO write is the final latency stage, so only LATENCY-1 registers
  // sit between the accept and the push.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push       = st0_valid;
      assign push_rdata = st0_rdata;
      assign push_err   = st0_err;
    end else begin : g_pipe
      localparam int NS = LATENCY - 1;
      logic [NS-1:0] p_valid;
      logic [31:0]   p_rdata [NS];
      logic [NS-1:0] p_err;

      // Valid bits of the response pipeline; cleared on reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          p_valid <= '0;
        end else begin
          p_valid[0] <= st0_valid;
          for (int i = 1; i < NS; i++) p_valid[i] <= p_valid[i-1];
        end
      end

      // Payload of the response pipeline; qualified by the valid bits.
      always_ff @(posedge clk) begin
        p_rdata[0] <= st0_rdata;
        p_err[0]   <= st0_err;
        for (int i = 1; i < NS; i++) begin
          p_rdata[i] <= p_rdata[i-1];
          p_err[i]   <= p_err[i-1];
        end
      end

      assign push       = p_valid[NS-1];
      assign push_rdata = p_rdata[NS-1];
      assign push_err   = p_err[NS-1];
    end
  endgenerate

  logic [31:0]   fifo_rdata [FD];
  logic [FD-1:0] fifo_err;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Response FIFO storage.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rdata[wr_ptr] <= push_rdata;
      fifo_err[wr_ptr]   <= push_err;
    end
  end

  // Outputs are forced to zero when empty so reset/idle values are clean.
  assign rsp_valid = (fifo_count != '0);
  assign rsp_rdata = rsp_valid ? fifo_rdata[rd_ptr] : '0;
  assign rsp_err   = rsp_valid & fifo_err[rd_ptr];

  // A push into a full FIFO without a simultaneous pop would drop a response.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_count == MAX_OUT)));

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized
// traffic compared against a byte-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  logic [7:0]  model_mem [4*DEPTH];

  // Reference model: byte-addressed memory, returns {err, rdata}.
  function automatic logic [32:0] model_apply(logic w, logic [31:0] a, logic [31:0] d,
                                              logic [1:0] s, logic u);
    int nb;
    int base;
    logic err;
    logic [31:0] val;
    nb  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    err = (s == 2'b11) || (a >= 32'(4*DEPTH));
`ifdef DMEM_MISALIGN_ERR_EN
    if ((a % 32'(nb)) != 0) err = 1'b1;
`endif
    if (err) return {1'b1, 32'h0};
    base = int'(a - (a % 32'(nb)));
    if (w) begin
      for (int i = 0; i < nb; i++) model_mem[base+i] = d[8*i +: 8];
      return {1'b0, 32'h0};
    end
    val = '0;
    for (int i = 0; i < nb; i++) val = val | (32'(model_mem[base+i]) << (8*i));
    if (nb < 4 && !u && val[8*nb-1]) val = val | ~((32'h1 << (8*nb)) - 32'h1);
    return {1'b0, val};
  endfunction

  // Observe accepts (feed the model) and pops (collect actual responses).
  always @(negedge clk) begin
    if (!rst && req_valid && req_ready)
      exp_q.push_back(model_apply(req_write, req_addr, req_wdata, req_size, req_unsigned));
    if (!rst && rsp_valid && rsp_ready)
      got_q.push_back({rsp_err, rsp_rdata});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic u, output int acc);
    req_write = w; req_addr = a; req_wdata = d; req_size = s; req_unsigned = u;
    req_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
    end
    req_valid = 1'b0;
    if (acc < 0) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout addr=%h got no accept want accept", a);
    end
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      if (!rsp_valid && got_q.size() == exp_q.size()) begin
        ok = 1'b1;
        break;
      end
    end
    sync();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rsp_rdata got=%h want=0", rsp_rdata); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_err got=%b want=0", rsp_err); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_req_ready got=%b want=1", req_ready); end
    sync();
  endtask

  task automatic test_init;
    int acc;
    bit ok;
    rsp_ready = 1'b1;
    for (int w = 0; w < 16; w++) send(1'b1, 32'(w*4), $urandom, 2'b10, 1'b0, acc);
    drain(ok);
    vectors++;
    if (!ok || got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL init_drain got=%0d responses want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL init_rsp[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_directed;
    int acc;
    bit ok;
    logic [32:0] want [7];
    want = '{{1'b0, 32'h0}, {1'b0, 32'hDEADBEEF}, {1'b0, 32'hFFFFFFDE}, {1'b0, 32'h000000DE},
             {1'b0, 32'hFFFFBEEF}, {1'b0, 32'h0}, {1'b0, 32'hDEAD5AEF}};
    rsp_ready = 1'b1;
    send(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, acc);
    send(1'b0, 32'h10, 32'h0,        2'b10, 1'b0, acc);
    send(1'b0, 32'h13, 32'h0,        2'b00, 1'b0, acc);
    send(1'b0, 32'h13, 32'h0,        2'b00, 1'b1, acc);
    send(1'b0, 32'h10, 32'h0,        2'b01, 1'b0, acc);
    send(1'b1, 32'h11, 32'hFFFFFF5A, 2'b00, 1'b0, acc);
    send(1'b0, 32'h10, 32'h0,        2'b10, 1'b0, acc);
    drain(ok);
    vectors++;
    if (!ok || got_q.size() != 7) begin
      miscompares++; $display("FAIL directed_count got=%0d want=7", got_q.size());
    end
    for (int i = 0; i < 7 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== want[i]) begin
        miscompares++; $display("FAIL directed_rsp[%0d] got=%h want=%h", i, got_q[i], want[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_latency;
    int acc;
    int seen;
    bit ok;
    rsp_ready = 1'b1;
    send(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, acc);
    seen = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = cyc; break; end
    end
    vectors++;
    if (seen - acc !== LAT - 1) begin
      miscompares++; $display("FAIL latency got=%0d edges want=%0d", seen - acc, LAT - 1);
    end
    vectors++;
    if (rsp_rdata !== 32'hDEAD5AEF) begin
      miscompares++; $display("FAIL latency_rdata got=%h want=dead5aef", rsp_rdata);
    end
    drain(ok);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_misalign;
    int acc;
    bit ok;
    logic [32:0] want [6];
`ifdef DMEM_MISALIGN_ERR_EN
    want = '{{1'b1, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0},
             {1'b1, 32'h0}, {1'b0, 32'hDEAD5AEF}};
`else
    want = '{{1'b0, 32'hDEAD5AEF}, {1'b1, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0},
             {1'b0, 32'h0}, {1'b0, 32'hDEAD1234}};
`endif
    rsp_ready = 1'b1;
    send(1'b0, 32'h12,        32'h0,        2'b10, 1'b0, acc);
    send(1'b0, 32'(4*DEPTH),  32'h0,        2'b10, 1'b0, acc);
    send(1'b0, 32'h10,        32'h0,        2'b11, 1'b0, acc);
    send(1'b1, 32'(4*DEPTH+4), 32'h11111111, 2'b10, 1'b0, acc);
    send(1'b1, 32'h11,        32'hABCD1234, 2'b01, 1'b0, acc);
    send(1'b0, 32'h10,        32'h0,        2'b10, 1'b0, acc);
    drain(ok);
    vectors++;
    if (!ok || got_q.size() != 6) begin
      miscompares++; $display("FAIL misalign_count got=%0d want=6", got_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== want[i]) begin
        miscompares++; $display("FAIL misalign_rsp[%0d] got=%h want=%h", i, got_q[i], want[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure;
    int cnt;
    int cnt2;
    bit ok;
    rsp_ready = 1'b0;
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_wdata = '0;
    req_addr = 32'($urandom_range(0, 15)) << 2;
    req_valid = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready) cnt++;
      @(posedge clk);
      #1 req_addr = 32'($urandom_range(0, 15)) << 2;
    end
    @(negedge clk);
    vectors++; if (cnt !== LAT + 1) begin miscompares++; $display("FAIL bp_accepts got=%0d want=%0d", cnt, LAT + 1); end
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready got=%b want=0", req_ready); end
    repeat (3) begin @(posedge clk); @(negedge clk); end
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, exp_q[0]}) begin
      miscompares++; $display("FAIL bp_hold got=%b/%h want=1/%h", rsp_valid, {rsp_err, rsp_rdata}, exp_q[0]);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    cnt2 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (req_ready) cnt2++;
      @(posedge clk);
      #1 req_addr = 32'($urandom_range(0, 15)) << 2;
    end
    req_valid = 1'b0;
    vectors++; if (cnt2 < 1) begin miscompares++; $display("FAIL bp_resume got=%0d accepts want>=1", cnt2); end
    drain(ok);
    vectors++;
    if (!ok || got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL bp_drain got=%0d responses want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL bp_rsp[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    int acc;
    int first;
    bit ok;
    rsp_ready = 1'b1;
    first = 0;
    acc = 0;
    for (int n = 0; n < 16; n++) begin
      send(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
           2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), acc);
      if (n == 0) first = acc;
    end
    vectors++;
    if (acc - first !== 15) begin
      miscompares++; $display("FAIL b2b_span got=%0d cycles want=15", acc - first);
    end
    drain(ok);
    vectors++;
    if (!ok || got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL b2b_drain got=%0d responses want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL b2b_rsp[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random;
    bit done;
    bit ok;
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          logic [31:0] a;
          logic [1:0] s;
          int acc;
          a = 32'($urandom_range(0, 63));
          case ($urandom_range(0, 9))
            0: a = 32'(4*DEPTH) + 32'($urandom_range(0, 4000));
            1: a = 32'hFFFF_FFFC;
            default: ;
          endcase
          s = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
          send(1'($urandom_range(0, 1)), a, $urandom, s, 1'($urandom_range(0, 1)), acc);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rsp_ready = 1'b1;
    drain(ok);
    vectors++;
    if (!ok || got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL rand_drain got=%0d responses want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL rand_rsp[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_reset;
    int acc;
    int seen;
    bit ok;
    rsp_ready = 1'b1;
    send(1'b1, 32'h24, 32'hCAFEF00D, 2'b10, 1'b0, acc);
    drain(ok);
    vectors++;
    if (!ok || got_q.size() != 1 || got_q[0] !== 33'h0) begin
      miscompares++; $display("FAIL mrst_store got=%0d responses want=1 clean store response", got_q.size());
    end
    got_q.delete(); exp_q.delete();
    rsp_ready = 1'b0;
    send(1'b0, 32'h24, 32'h0, 2'b10, 1'b0, acc);
    send(1'b0, 32'h28, 32'h0, 2'b10, 1'b0, acc);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    rsp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL mrst_rsp_valid got=%0d cycles want=0", seen); end
    vectors++; if (got_q.size() !== 0) begin miscompares++; $display("FAIL mrst_responses got=%0d want=0", got_q.size()); end
    sync();
    send(1'b0, 32'h24, 32'h0, 2'b10, 1'b0, acc);
    drain(ok);
    vectors++;
    if (!ok || got_q.size() != 1) begin
      miscompares++; $display("FAIL mrst_load_count got=%0d want=1", got_q.size());
    end else if (got_q[0] !== {1'b0, 32'hCAFEF00D}) begin
      miscompares++; $display("FAIL mrst_load got=%h want=0cafef00d", got_q[0]);
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_latency();
    test_misalign();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
